// File: rtl/ann_pkg.sv
// ann_pkg: shared types and constants for the ANN coefficient loader.
//   loader_state_t  loader FSM states; CHECK exists only with ANN_LOADER_CHECKSUM_EN
//   ANN_DATA_W      stream/array word width
//   LAYER_0..2      valid layer codes, LAYER_RSVD reserved code
package ann_pkg;

  localparam int ANN_DATA_W = 16;

  localparam logic [1:0] LAYER_0    = 2'd0;
  localparam logic [1:0] LAYER_1    = 2'd1;
  localparam logic [1:0] LAYER_2    = 2'd2;
  localparam logic [1:0] LAYER_RSVD = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_IMG,
    ST_LOAD_W,
`ifdef ANN_LOADER_CHECKSUM_EN
    ST_CHECK,
`endif
    ST_DONE
  } loader_state_t;

endpackage

// File: rtl/ann_coef_loader_if.sv
// ann_coef_loader_if: valid/ready word stream from the host/SPI side into the loader.
//   in_valid  word valid (master -> slave)
//   in_data   word       (master -> slave)
//   in_ready  slave accepts a word this cycle (slave -> master)
interface ann_coef_loader_if #(
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/ann_word_counter.sv
// ann_word_counter: two-level (node, input) word counter.
//   clk, rst   clock, async active-high reset
//   clr        synchronous clear, wins over en
//   en         advance by one word
//   node, inp  current node row / input index
//   last_inp   inp is at IMAGE_SIZE-1
//   last_word  final word of a weight set (last node, last input)
module ann_word_counter #(
  parameter int NODES      = 16,
  parameter int IMAGE_SIZE = 64,
  localparam int NW = $clog2(NODES),
  localparam int IW = $clog2(IMAGE_SIZE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [NW-1:0] node,
  output logic [IW-1:0] inp,
  output logic          last_inp,
  output logic          last_word
);

  assign last_inp  = (inp == IW'(IMAGE_SIZE - 1));
  assign last_word = last_inp && (node == NW'(NODES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      node <= '0;
      inp  <= '0;
    end else if (clr) begin
      node <= '0;
      inp  <= '0;
    end else if (en) begin
      if (last_inp) begin
        inp  <= '0;
        node <= node + NW'(1);
      end else begin
        inp <= inp + IW'(1);
      end
    end
  end

endmodule

// File: rtl/ann_coef_loader.sv
// ann_coef_loader: fills the ANN image and weight arrays from a word stream.
// A full load (start_load) takes IMAGE_SIZE image words then NODES*IMAGE_SIZE
// weight words for layer 0; a reload (request_coef) takes weight words only.
// Optional feature macro: ANN_LOADER_CHECKSUM_EN -- one trailer word after the
// data must make the 16-bit wrapping sum of the transaction zero.
// Ports:
//   clk, rst               clock, async active-high reset
//   start_load             pulse, begin full load
//   request_coef           level, weight reload for coef_select
//   coef_select            layer 0..2, 3 reserved (rejected with load_err)
//   stream                 word stream (slave side)
//   image                  IMAGE_SIZE words
//   weights                NODES x IMAGE_SIZE words, [node][input]
//   image_weights_loaded   one-cycle pulse, set complete
//   loaded_layer           layer currently held in weights
//   load_err               one-cycle pulse, rejected request / bad checksum
module ann_coef_loader
  import ann_pkg::*;
#(
  parameter int IMAGE_SIZE = 64,
  parameter int NODES      = 16,
  parameter int DATA_W     = ANN_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_load,
  input  logic              request_coef,
  input  logic [1:0]        coef_select,
  ann_coef_loader_if.slave  stream,
  output logic [DATA_W-1:0] image [IMAGE_SIZE],
  output logic [DATA_W-1:0] weights [NODES][IMAGE_SIZE],
  output logic              image_weights_loaded,
  output logic [1:0]        loaded_layer,
  output logic              load_err
);

  localparam int NW = $clog2(NODES);
  localparam int IW = $clog2(IMAGE_SIZE);

  loader_state_t state;
  logic          in_ready_q;
  logic [1:0]    layer_sel;
  logic          xfer;
  logic          cnt_clr;
  logic [NW-1:0] cnt_node;
  logic [IW-1:0] cnt_inp;
  logic          cnt_last_inp;
  logic          cnt_last_word;

`ifdef ANN_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;
  logic [DATA_W-1:0] chk;
  assign chk = stream.in_data + sum_q;
`endif

  assign stream.in_ready = in_ready_q;
  assign xfer            = stream.in_valid && in_ready_q;

  // Held clear while idle; also cleared at the image->weights boundary so
  // weight indexing starts at node 0 regardless of image length.
  assign cnt_clr = (state == ST_IDLE) ||
                   ((state == ST_LOAD_IMG) && xfer && cnt_last_inp);

  ann_word_counter #(
    .NODES      (NODES),
    .IMAGE_SIZE (IMAGE_SIZE)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (cnt_clr),
    .en        (xfer),
    .node      (cnt_node),
    .inp       (cnt_inp),
    .last_inp  (cnt_last_inp),
    .last_word (cnt_last_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= ST_IDLE;
      in_ready_q           <= 1'b0;
      image_weights_loaded <= 1'b0;
      load_err             <= 1'b0;
      loaded_layer         <= LAYER_0;
      layer_sel            <= LAYER_0;
`ifdef ANN_LOADER_CHECKSUM_EN
      sum_q                <= '0;
`endif
    end else begin
      image_weights_loaded <= 1'b0;
      load_err             <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_load) begin
            state      <= ST_LOAD_IMG;
            in_ready_q <= 1'b1;
            layer_sel  <= LAYER_0;
`ifdef ANN_LOADER_CHECKSUM_EN
            sum_q      <= '0;
`endif
          end else if (request_coef) begin
            if (coef_select == LAYER_RSVD) begin
              load_err <= 1'b1;
            end else begin
              state      <= ST_LOAD_W;
              in_ready_q <= 1'b1;
              layer_sel  <= coef_select;
`ifdef ANN_LOADER_CHECKSUM_EN
              sum_q      <= '0;
`endif
            end
          end
        end
        ST_LOAD_IMG: begin
          if (xfer) begin
`ifdef ANN_LOADER_CHECKSUM_EN
            sum_q <= sum_q + stream.in_data;
`endif
            if (cnt_last_inp) state <= ST_LOAD_W;
          end
        end
        ST_LOAD_W: begin
          if (xfer) begin
`ifdef ANN_LOADER_CHECKSUM_EN
            sum_q <= sum_q + stream.in_data;
            if (cnt_last_word) state <= ST_CHECK;
`else
            if (cnt_last_word) begin
              state                <= ST_DONE;
              in_ready_q           <= 1'b0;
              image_weights_loaded <= 1'b1;
              loaded_layer         <= layer_sel;
            end
`endif
          end
        end
`ifdef ANN_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (xfer) begin
            in_ready_q <= 1'b0;
            if (chk == '0) begin
              state                <= ST_DONE;
              image_weights_loaded <= 1'b1;
              loaded_layer         <= layer_sel;
            end else begin
              state    <= ST_IDLE;
              load_err <= 1'b1;
            end
          end
        end
`endif
        // The pulse is raised on entry so it is visible exactly during DONE.
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state      <= ST_IDLE;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < IMAGE_SIZE; i++) image[i] <= '0;
      for (int n = 0; n < NODES; n++)
        for (int i = 0; i < IMAGE_SIZE; i++) weights[n][i] <= '0;
    end else if (xfer) begin
      if (state == ST_LOAD_IMG) image[cnt_inp] <= stream.in_data;
      else if (state == ST_LOAD_W) weights[cnt_node][cnt_inp] <= stream.in_data;
    end
  end

endmodule

// File: tb/tb_ann_coef_loader.sv
module tb_ann_coef_loader;
  import ann_pkg::*;

  localparam int IS = 64;
  localparam int NN = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_load;
  logic        request_coef;
  logic [1:0]  coef_select;
  logic [15:0] image [IS];
  logic [15:0] weights [NN][IS];
  logic        iwl;
  logic [1:0]  loaded_layer;
  logic        load_err;

  ann_coef_loader_if #(.DATA_W(16)) s_if ();

  ann_coef_loader #(.IMAGE_SIZE(IS), .NODES(NN), .DATA_W(16)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .start_load           (start_load),
    .request_coef         (request_coef),
    .coef_select          (coef_select),
    .stream               (s_if),
    .image                (image),
    .weights              (weights),
    .image_weights_loaded (iwl),
    .loaded_layer         (loaded_layer),
    .load_err             (load_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: expected array contents and layer, plus the current transaction.
  logic [15:0] m_img [IS];
  logic [15:0] m_w [NN][IS];
  logic [1:0]  m_layer;
  logic [15:0] tx_q [$];
`ifdef ANN_LOADER_CHECKSUM_EN
  bit          trailer_bad = 1'b0;
`endif

  function automatic int img_mismatch();
    int c = 0;
    for (int i = 0; i < IS; i++) if (image[i] !== m_img[i]) c++;
    return c;
  endfunction

  function automatic int w_mismatch();
    int c = 0;
    for (int n = 0; n < NN; n++)
      for (int i = 0; i < IS; i++) if (weights[n][i] !== m_w[n][i]) c++;
    return c;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < IS; i++) m_img[i] = '0;
    for (int n = 0; n < NN; n++) for (int i = 0; i < IS; i++) m_w[n][i] = '0;
    m_layer = 2'd0;
  endtask

  // Full load: first IS words are the image, the rest weights in [node][input] order.
  task automatic model_commit(input bit is_full, input logic [1:0] layer);
    int base = is_full ? IS : 0;
    if (is_full) for (int i = 0; i < IS; i++) m_img[i] = tx_q[i];
    for (int n = 0; n < NN; n++)
      for (int i = 0; i < IS; i++) m_w[n][i] = tx_q[base + n * IS + i];
    m_layer = layer;
  endtask

  task automatic build_pattern_full();
    tx_q.delete();
    for (int k = 0; k < IS; k++) tx_q.push_back(16'(32'h1000 + k));
    for (int n = 0; n < NN; n++)
      for (int i = 0; i < IS; i++) tx_q.push_back(16'((n << 8) | i));
  endtask

  task automatic build_random(input bit is_full);
    tx_q.delete();
    for (int k = 0; k < (is_full ? IS + NN * IS : NN * IS); k++) tx_q.push_back(16'($urandom));
  endtask

  // Called at a negedge; returns at the negedge after the word was accepted.
  task automatic send_word(input logic [15:0] d, output bit ok);
    int t = 0;
    ok = 1'b0;
    s_if.in_valid = 1'b1;
    s_if.in_data  = d;
    while (!ok && t < 50) begin
      if (s_if.in_ready === 1'b1) ok = 1'b1;
      @(negedge clk);
      t++;
    end
  endtask

  // stall_mode: 0 none, 1 three idle cycles every 10 words, 2 random idles.
  task automatic send_stream(input int stall_mode, input int inject_at, input int limit,
                             output int to, output int drop);
    bit          ok;
    logic [15:0] sum = '0;
    logic [15:0] tr;
    int          n = (limit < 0) ? tx_q.size() : limit;
    int          idle;
    to = 0; drop = 0;
    for (int k = 0; k < n; k++) begin
      idle = 0;
      if (stall_mode == 1 && k > 0 && (k % 10) == 0) idle = 3;
      if (stall_mode == 2 && $urandom_range(3) == 0) idle = $urandom_range(1, 3);
      if (idle > 0) begin
        s_if.in_valid = 1'b0;
        repeat (idle) begin
          if (s_if.in_ready !== 1'b1) drop++;
          @(negedge clk);
        end
      end
      if (k == inject_at) start_load = 1'b1;
      send_word(tx_q[k], ok);
      start_load = 1'b0;
      if (!ok) to++;
      sum = sum + tx_q[k];
    end
`ifdef ANN_LOADER_CHECKSUM_EN
    if (limit < 0) begin
      tr = 16'h0000 - sum;
      if (trailer_bad) tr = tr + 16'd1;
      send_word(tr, ok);
      if (!ok) to++;
    end
`else
    tr = sum;
`endif
    s_if.in_valid = 1'b0;
  endtask

  task automatic run_full_load(input string name, input int stall_mode, input int inject_at,
                               input bit with_req);
    int to, drop;
    start_load = 1'b1;
    if (with_req) begin request_coef = 1'b1; coef_select = 2'd1; end
    @(negedge clk);
    start_load = 1'b0; request_coef = 1'b0;
    total++;
    if (s_if.in_ready !== 1'b1) begin bad++; $display("FAIL %s_ready_start: got %b want 1", name, s_if.in_ready); end
    send_stream(stall_mode, inject_at, -1, to, drop);
    total++;
    if (to !== 0) begin bad++; $display("FAIL %s_timeout: %0d words not accepted", name, to); end
    if (stall_mode != 0) begin
      total++;
      if (drop !== 0) begin bad++; $display("FAIL %s_ready_stall: in_ready low %0d stall cycles, want 0", name, drop); end
    end
    total++;
    if (iwl !== 1'b1) begin bad++; $display("FAIL %s_pulse: got %b want 1", name, iwl); end
    model_commit(1'b1, LAYER_0);
    total++;
    if (loaded_layer !== m_layer) begin bad++; $display("FAIL %s_layer: got %0d want %0d", name, loaded_layer, m_layer); end
    @(negedge clk);
    total++;
    if (iwl !== 1'b0 || s_if.in_ready !== 1'b0) begin
      bad++; $display("FAIL %s_after: iwl=%b in_ready=%b want 0 0", name, iwl, s_if.in_ready);
    end
    total++;
    if (img_mismatch() !== 0) begin bad++; $display("FAIL %s_image: %0d words differ, want 0", name, img_mismatch()); end
    total++;
    if (w_mismatch() !== 0) begin bad++; $display("FAIL %s_weights: %0d words differ, want 0", name, w_mismatch()); end
  endtask

  task automatic run_reload(input string name, input logic [1:0] layer, input int stall_mode);
    int to, drop;
    request_coef = 1'b1; coef_select = layer;
    @(negedge clk);
    request_coef = 1'b0;
    total++;
    if (s_if.in_ready !== 1'b1) begin bad++; $display("FAIL %s_ready_start: got %b want 1", name, s_if.in_ready); end
    send_stream(stall_mode, -1, -1, to, drop);
    total++;
    if (to !== 0 || drop !== 0) begin bad++; $display("FAIL %s_stream: timeouts=%0d ready_drops=%0d want 0 0", name, to, drop); end
    total++;
    if (iwl !== 1'b1) begin bad++; $display("FAIL %s_pulse: got %b want 1", name, iwl); end
    model_commit(1'b0, layer);
    total++;
    if (loaded_layer !== m_layer) begin bad++; $display("FAIL %s_layer: got %0d want %0d", name, loaded_layer, m_layer); end
    @(negedge clk);
    total++;
    if (img_mismatch() !== 0 || w_mismatch() !== 0) begin
      bad++; $display("FAIL %s_arrays: image diffs=%0d weight diffs=%0d want 0 0", name, img_mismatch(), w_mismatch());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_load = 1'b0; request_coef = 1'b0; coef_select = 2'd0;
    s_if.in_valid = 1'b0; s_if.in_data = '0;
    model_clear();
    repeat (3) @(negedge clk);
    total++;
    if (s_if.in_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", s_if.in_ready); end
    total++;
    if (iwl !== 1'b0 || load_err !== 1'b0) begin bad++; $display("FAIL reset_pulses: iwl=%b err=%b want 0 0", iwl, load_err); end
    total++;
    if (loaded_layer !== 2'd0) begin bad++; $display("FAIL reset_layer: got %0d want 0", loaded_layer); end
    total++;
    if (img_mismatch() !== 0 || w_mismatch() !== 0) begin
      bad++; $display("FAIL reset_arrays: image diffs=%0d weight diffs=%0d want 0 0", img_mismatch(), w_mismatch());
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_load();
    build_pattern_full();
    run_full_load("full", 0, -1, 1'b0);
    total++;
    if (image[5] !== 16'h1005) begin bad++; $display("FAIL full_image5: got %h want 1005", image[5]); end
    total++;
    if (weights[3][7] !== 16'h0307) begin bad++; $display("FAIL full_w37: got %h want 0307", weights[3][7]); end
  endtask

  task automatic test_stall();
    build_pattern_full();
    run_full_load("stall", 1, -1, 1'b0);
  endtask

  task automatic test_reload();
    tx_q.delete();
    for (int k = 0; k < NN * IS; k++) tx_q.push_back(16'hBEEF);
    run_reload("reload2", LAYER_2, 0);
    total++;
    if (weights[NN-1][IS-1] !== 16'hBEEF || image[0] !== 16'h1000) begin
      bad++; $display("FAIL reload2_spot: w_last=%h img0=%h want BEEF 1000", weights[NN-1][IS-1], image[0]);
    end
    request_coef = 1'b1; coef_select = LAYER_RSVD;
    @(negedge clk);
    request_coef = 1'b0;
    total++;
    if (load_err !== 1'b1 || s_if.in_ready !== 1'b0) begin
      bad++; $display("FAIL rsvd_err: err=%b in_ready=%b want 1 0", load_err, s_if.in_ready);
    end
    @(negedge clk);
    total++;
    if (load_err !== 1'b0 || s_if.in_ready !== 1'b0 || loaded_layer !== 2'd2) begin
      bad++; $display("FAIL rsvd_after: err=%b in_ready=%b layer=%0d want 0 0 2", load_err, s_if.in_ready, loaded_layer);
    end
  endtask

  task automatic test_collision();
    build_random(1'b1);
    run_full_load("collide", 0, IS + 100, 1'b1);
  endtask

  task automatic test_reset_mid();
    int to, drop, pulses = 0;
    build_pattern_full();
    start_load = 1'b1;
    @(negedge clk);
    start_load = 1'b0;
    send_stream(0, -1, 500, to, drop);
    rst = 1'b1;
    #1;
    model_clear();
    total++;
    if (s_if.in_ready !== 1'b0 || iwl !== 1'b0 || load_err !== 1'b0 || loaded_layer !== 2'd0) begin
      bad++; $display("FAIL midrst_outputs: rdy=%b iwl=%b err=%b layer=%0d want 0 0 0 0",
                      s_if.in_ready, iwl, load_err, loaded_layer);
    end
    total++;
    if (img_mismatch() !== 0 || w_mismatch() !== 0) begin
      bad++; $display("FAIL midrst_arrays: image diffs=%0d weight diffs=%0d want 0 0", img_mismatch(), w_mismatch());
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (8) begin
      if (iwl !== 1'b0) pulses++;
      @(negedge clk);
    end
    total++;
    if (pulses !== 0) begin bad++; $display("FAIL midrst_pulse: %0d pulse cycles want 0", pulses); end
    build_random(1'b1);
    run_full_load("fresh", 2, -1, 1'b0);
  endtask

  task automatic test_random_reload();
    logic [1:0] layer;
    for (int r = 0; r < 3; r++) begin
      layer = 2'($urandom_range(0, 2));
      build_random(1'b0);
      run_reload("rnd_reload", layer, 2);
    end
  endtask

`ifdef ANN_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    int to, drop;
    logic [1:0] prev = m_layer;
    logic [1:0] layer = (prev == LAYER_1) ? LAYER_2 : LAYER_1;
    build_random(1'b0);
    trailer_bad = 1'b1;
    request_coef = 1'b1; coef_select = layer;
    @(negedge clk);
    request_coef = 1'b0;
    send_stream(0, -1, -1, to, drop);
    trailer_bad = 1'b0;
    total++;
    if (load_err !== 1'b1 || iwl !== 1'b0) begin
      bad++; $display("FAIL cksum_bad: err=%b iwl=%b want 1 0", load_err, iwl);
    end
    total++;
    if (loaded_layer !== prev) begin bad++; $display("FAIL cksum_layer: got %0d want %0d", loaded_layer, prev); end
    @(negedge clk);
    total++;
    if (s_if.in_ready !== 1'b0 || iwl !== 1'b0 || load_err !== 1'b0) begin
      bad++; $display("FAIL cksum_after: rdy=%b iwl=%b err=%b want 0 0 0", s_if.in_ready, iwl, load_err);
    end
    build_random(1'b0);
    run_reload("cksum_good", layer, 0);
  endtask
`endif

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_load();
    test_stall();
    test_reload();
    test_collision();
    test_reset_mid();
    test_random_reload();
`ifdef ANN_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
